ras_stack: RTL

Parametrised LIFO successor to the core's basic stack, sized for use as a return-address stack in the fetch/branch-prediction path.

---
 rtl/ras_stack_if.sv | 37 +++
 rtl/ras_stack.sv | 98 +++++++++
 2 files changed

// File: rtl/ras_stack_if.sv
// rtl/ras_stack_if.sv - control/data bundle between a return-address stack and its user.
interface ras_stack_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic             flush;
   logic             restore;
   logic [PTR_W-1:0] restore_ptr;
   logic [CNT_W-1:0] restore_count;
   logic [WIDTH-1:0] top_out;
   logic             top_valid;
   logic             empty;
   logic             full;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] ckpt_ptr;
   logic [CNT_W-1:0] ckpt_count;
   logic             overflow;
   logic             underflow;

   modport master (
      output push, pop, data_in, flush, restore, restore_ptr, restore_count,
      input  top_out, top_valid, empty, full, count, ckpt_ptr, ckpt_count,
             overflow, underflow
   );

   modport slave (
      input  push, pop, data_in, flush, restore, restore_ptr, restore_count,
      output top_out, top_valid, empty, full, count, ckpt_ptr, ckpt_count,
             overflow, underflow
   );
endinterface

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - LIFO return-address stack with replace-top, circular overwrite and checkpoint restore.
module ras_stack #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int OVERWRITE = 1,
   parameter int PTR_W     = $clog2(DEPTH),
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input logic        clk,
   input logic        rst,
   ras_stack_if.slave s
);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] tp_q, tp_d, tp_inc, tp_dec, wr_addr;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             wr_en;
   logic             is_empty, is_full;

   assign is_empty = (cnt_q == '0);
   assign is_full  = (cnt_q == CNT_FULL);
   assign tp_inc   = (tp_q == PTR_LAST) ? '0 : tp_q + PTR_ONE;
   assign tp_dec   = (tp_q == '0) ? PTR_LAST : tp_q - PTR_ONE;

   // Priority flush > restore > push/pop; the lower actions and their error pulses are dropped.
   always_comb begin
      tp_d    = tp_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_addr = tp_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (s.flush) begin
         tp_d  = '0;
         cnt_d = '0;
      end else if (s.restore) begin
         tp_d  = s.restore_ptr;
         cnt_d = (s.restore_count > CNT_FULL) ? CNT_FULL : s.restore_count;
      end else if (s.push && s.pop && !is_empty) begin
         wr_en   = 1'b1;
         wr_addr = tp_dec;
      end else if (s.push) begin
         if (!is_full) begin
            wr_en = 1'b1;
            tp_d  = tp_inc;
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            ovf_d = 1'b1;
            if (OVERWRITE != 0) begin
               wr_en = 1'b1;
               tp_d  = tp_inc;
            end
         end
      end else if (s.pop) begin
         if (!is_empty) begin
            tp_d  = tp_dec;
            cnt_d = cnt_q - CNT_ONE;
         end else begin
            unf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[wr_addr] <= s.data_in;
      end
   end

   assign s.top_out    = is_empty ? '0 : mem_q[tp_dec];
   assign s.top_valid  = !is_empty;
   assign s.empty      = is_empty;
   assign s.full       = is_full;
   assign s.count      = cnt_q;
   assign s.ckpt_ptr   = tp_q;
   assign s.ckpt_count = cnt_q;
   assign s.overflow   = ovf_q;
   assign s.underflow  = unf_q;
endmodule
